lstm_seq_layer: RTL

Sequence-level successor to the single-step LSTM layer. It runs UNITS_NUM gate lanes over a whole input sequence of runtime length, with per-lane MACs for the four gates. Internal h/c state registers feed h back into the input stream, and each timestep's h is presented on a valid/ready output. It sits between the feature front-end (serial x stream, combinational weight ROM) and the dense/classifier stage.

---
 rtl/lstm_seq_layer.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lstm_seq_layer.sv
// Sequence LSTM layer: UNITS_NUM parallel lanes, hard-sigmoid gates, h fed back per step.
// Define LSTM_SAT_FLAG_EN to add a sticky sat_flag output.
module lstm_seq_layer #(
  parameter int INPUT_SIZE = 26,
  parameter int UNITS_NUM  = 5,
  parameter int D_WL       = 22,
  parameter int FL         = 12,
  parameter int SEQ_WL     = 8,
  localparam int AW = $clog2(INPUT_SIZE + UNITS_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SEQ_WL-1:0]         seq_len,
  input  logic                      clear_state,
  input  logic [D_WL-1:0]           x_in,
  input  logic                      x_valid,
  output logic                      x_ready,
  output logic [AW-1:0]             w_addr,
  input  logic [UNITS_NUM*D_WL-1:0] wi,
  input  logic [UNITS_NUM*D_WL-1:0] wf,
  input  logic [UNITS_NUM*D_WL-1:0] wg,
  input  logic [UNITS_NUM*D_WL-1:0] wo,
  input  logic [UNITS_NUM*D_WL-1:0] bi,
  input  logic [UNITS_NUM*D_WL-1:0] bf,
  input  logic [UNITS_NUM*D_WL-1:0] bg,
  input  logic [UNITS_NUM*D_WL-1:0] bo,
  output logic [UNITS_NUM*D_WL-1:0] h_o,
  output logic [UNITS_NUM*D_WL-1:0] c_o,
  output logic                      h_valid,
  input  logic                      h_ready,
  output logic                      h_last,
  output logic [SEQ_WL-1:0]         step_idx,
  output logic                      busy,
`ifdef LSTM_SAT_FLAG_EN
  output logic                      sat_flag,
`endif
  output logic                      done
);

  localparam int MW  = 2 * D_WL;
  localparam int PW  = MW + 1;
  localparam int ACW = MW + AW;
  localparam int WV  = ACW + 1;

  localparam logic signed [WV-1:0] SMAX = WV'((64'sd1 <<< (D_WL - 1)) - 64'sd1);
  localparam logic signed [WV-1:0] SMIN = WV'(-(64'sd1 <<< (D_WL - 1)));

  typedef logic signed [D_WL-1:0] word_t;
  typedef logic signed [ACW-1:0]  acc_t;

  localparam word_t ONE  = D_WL'(1 << FL);
  localparam word_t NONE = -ONE;
  localparam word_t HALF = D_WL'(1 << (FL - 1));

  typedef enum logic [2:0] {IDLE, ACC_X, ACC_H, ACT, UPD, OUT} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     k_q, k_d;
  logic [SEQ_WL-1:0] step_q, step_d;
  logic [SEQ_WL-1:0] len_q, len_d;
  logic              done_q, done_d;

  acc_t  acc_q  [4][UNITS_NUM], acc_d  [4][UNITS_NUM];
  word_t gate_q [4][UNITS_NUM], gate_d [4][UNITS_NUM];
  word_t h_q  [UNITS_NUM], h_d  [UNITS_NUM];
  word_t c_q  [UNITS_NUM], c_d  [UNITS_NUM];
  word_t ho_q [UNITS_NUM], ho_d [UNITS_NUM];
  word_t co_q [UNITS_NUM], co_d [UNITS_NUM];

  logic [UNITS_NUM*D_WL-1:0] wrow [4];
  logic [UNITS_NUM*D_WL-1:0] brow [4];
  word_t op;
  logic  acc_en;

  // gate order everywhere: 0=i, 1=f, 2=g, 3=o
  assign wrow[0] = wi;
  assign wrow[1] = wf;
  assign wrow[2] = wg;
  assign wrow[3] = wo;
  assign brow[0] = bi;
  assign brow[1] = bf;
  assign brow[2] = bg;
  assign brow[3] = bo;

  function automatic word_t sat(input logic signed [WV-1:0] v);
    if (v > SMAX) return word_t'(SMAX);
    if (v < SMIN) return word_t'(SMIN);
    return word_t'(v);
  endfunction

  function automatic word_t clamp(input word_t v, lo, hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic acc_t mac(input acc_t a, input word_t x, input word_t w);
    logic signed [MW-1:0] p;
    p = MW'(x) * MW'(w);
    return a + ACW'(p);
  endfunction

  function automatic logic signed [WV-1:0] pre_raw(input acc_t a, input word_t b);
    return (WV'(a) >>> FL) + WV'(b);
  endfunction

  function automatic word_t act(input word_t p, input logic is_g);
    logic signed [D_WL:0] s;
    if (is_g) return clamp(p, NONE, ONE);
    s = (D_WL+1)'(p >>> 2) + (D_WL+1)'(HALF);
    if (s < 0) return '0;
    if (s > (D_WL+1)'(ONE)) return ONE;
    return word_t'(s);
  endfunction

  function automatic logic signed [WV-1:0] cell_raw(input word_t f, c, i, g);
    logic signed [PW-1:0] m;
    m = PW'(f) * PW'(c) + PW'(i) * PW'(g);
    return WV'(m >>> FL);
  endfunction

  function automatic logic signed [WV-1:0] hid_raw(input word_t o, c);
    logic signed [PW-1:0] m;
    m = PW'(o) * PW'(clamp(c, NONE, ONE));
    return WV'(m >>> FL);
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    len_d   = len_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    gate_d  = gate_q;
    h_d     = h_q;
    c_d     = c_q;
    ho_d    = ho_q;
    co_d    = co_q;
    x_ready = 1'b0;
    h_valid = 1'b0;
    h_last  = 1'b0;
    w_addr  = '0;
    op      = '0;
    acc_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC_X;
          k_d     = '0;
          step_d  = '0;
          len_d   = (seq_len == '0) ? SEQ_WL'(1) : seq_len;
          for (int n = 0; n < UNITS_NUM; n++) begin
            for (int g = 0; g < 4; g++) acc_d[g][n] = '0;
            if (clear_state) begin
              h_d[n] = '0;
              c_d[n] = '0;
            end
          end
        end
      end
      ACC_X: begin
        x_ready = 1'b1;
        w_addr  = k_q;
        op      = word_t'(x_in);
        if (x_valid) begin
          acc_en = 1'b1;
          if (k_q == AW'(INPUT_SIZE - 1)) begin
            k_d     = '0;
            state_d = ACC_H;
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      ACC_H: begin
        w_addr = AW'(INPUT_SIZE) + k_q;
        acc_en = 1'b1;
        for (int j = 0; j < UNITS_NUM; j++)
          if (k_q == AW'(j)) op = h_q[j];
        if (k_q == AW'(UNITS_NUM - 1)) begin
          k_d     = '0;
          state_d = ACT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      ACT: begin
        for (int g = 0; g < 4; g++)
          for (int n = 0; n < UNITS_NUM; n++)
            gate_d[g][n] = act(sat(pre_raw(acc_q[g][n],
                             word_t'(brow[g][n*D_WL +: D_WL]))), g == 2);
        state_d = UPD;
      end
      UPD: begin
        for (int n = 0; n < UNITS_NUM; n++) begin
          c_d[n]  = sat(cell_raw(gate_q[1][n], c_q[n], gate_q[0][n], gate_q[2][n]));
          h_d[n]  = sat(hid_raw(gate_q[3][n], c_d[n]));
          co_d[n] = c_d[n];
          ho_d[n] = h_d[n];
        end
        state_d = OUT;
      end
      OUT: begin
        h_valid = 1'b1;
        h_last  = (step_q == len_q - SEQ_WL'(1));
        if (h_ready) begin
          if (h_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            step_d  = step_q + SEQ_WL'(1);
            state_d = ACC_X;
            for (int g = 0; g < 4; g++)
              for (int n = 0; n < UNITS_NUM; n++) acc_d[g][n] = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (acc_en) begin
      for (int g = 0; g < 4; g++)
        for (int n = 0; n < UNITS_NUM; n++)
          acc_d[g][n] = mac(acc_q[g][n], op, word_t'(wrow[g][n*D_WL +: D_WL]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      step_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      for (int n = 0; n < UNITS_NUM; n++) begin
        h_q[n]  <= '0;
        c_q[n]  <= '0;
        ho_q[n] <= '0;
        co_q[n] <= '0;
        for (int g = 0; g < 4; g++) begin
          acc_q[g][n]  <= '0;
          gate_q[g][n] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      step_q  <= step_d;
      len_q   <= len_d;
      done_q  <= done_d;
      h_q     <= h_d;
      c_q     <= c_d;
      ho_q    <= ho_d;
      co_q    <= co_d;
      acc_q   <= acc_d;
      gate_q  <= gate_d;
    end
  end

  for (genvar n = 0; n < UNITS_NUM; n++) begin : g_out
    assign h_o[n*D_WL +: D_WL] = ho_q[n];
    assign c_o[n*D_WL +: D_WL] = co_q[n];
  end

  assign step_idx = step_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

`ifdef LSTM_SAT_FLAG_EN
  function automatic logic ovf(input logic signed [WV-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (state_q == IDLE && start) begin
      sat_d = 1'b0;
    end else if (state_q == ACT) begin
      for (int g = 0; g < 4; g++)
        for (int n = 0; n < UNITS_NUM; n++)
          if (ovf(pre_raw(acc_q[g][n], word_t'(brow[g][n*D_WL +: D_WL]))))
            sat_d = 1'b1;
    end else if (state_q == UPD) begin
      for (int n = 0; n < UNITS_NUM; n++) begin
        if (ovf(cell_raw(gate_q[1][n], c_q[n], gate_q[0][n], gate_q[2][n])))
          sat_d = 1'b1;
        if (ovf(hid_raw(gate_q[3][n], sat(cell_raw(gate_q[1][n], c_q[n],
                                                   gate_q[0][n], gate_q[2][n])))))
          sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`endif

endmodule
